// File: rtl/sc_point_matrix_scanner.sv
`default_nettype none
// ============================================================================
// sc_point_matrix_scanner : snapshots ROWS point registers, scans them onto an
// LED matrix row by row. Optional inter-row blanking: POINTSCAN_GHOSTBLANK_EN.
// Revision: 1.0
// ============================================================================
module sc_point_matrix_scanner #(
    parameter int DATAWIDTH    = 8,
    parameter int ROWS         = 8,
    parameter int DWELL_CYCLES = 6250,
    parameter int BLANK_CYCLES = 50
) (
    input  logic                      SC_PointSCAN_CLOCK_50,
    input  logic                      SC_PointSCAN_RESET_InLow,
    input  logic                      SC_PointSCAN_enable_In,
    input  logic [ROWS*DATAWIDTH-1:0] SC_PointSCAN_rows_InBUS,
    output logic [ROWS-1:0]           SC_PointSCAN_row_OutBUS,
    output logic [DATAWIDTH-1:0]      SC_PointSCAN_col_OutBUS,
    output logic [$clog2(ROWS)-1:0]   SC_PointSCAN_rowindex_OutBUS,
    output logic                      SC_PointSCAN_frameDone_Out,
    output logic                      SC_PointSCAN_busy_Out
);

    localparam int IW      = $clog2(ROWS);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] ROW_LAST   = IW'(ROWS - 1);
`ifdef POINTSCAN_GHOSTBLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2,
        ST_BLANK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;
`endif

    state_t                             state_q, state_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic [ROWS-1:0][DATAWIDTH-1:0]     shadow_q, shadow_d;
    logic [ROWS-1:0]                    row_q, row_d;
    logic [DATAWIDTH-1:0]               col_q, col_d;
    logic                               done_q, done_d;
    logic                               busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (SC_PointSCAN_enable_In) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shadow_d = SC_PointSCAN_rows_InBUS;
                idx_d    = '0;
                cnt_d    = '0;
                state_d  = ST_SHOW;
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (idx_q == ROW_LAST) begin
                        done_d  = 1'b1;
                        state_d = SC_PointSCAN_enable_In ? ST_LOAD : ST_IDLE;
                    end else begin
`ifdef POINTSCAN_GHOSTBLANK_EN
                        state_d = ST_BLANK;
`else
                        idx_d   = idx_q + IW'(1);
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef POINTSCAN_GHOSTBLANK_EN
            // Index advances only when the next row is actually lit.
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they switch with it.
        row_d  = '1;
        col_d  = '0;
        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_SHOW) begin
            row_d = ~(ROWS'(1) << idx_d);
            col_d = shadow_d[idx_d];
        end
    end

    always_ff @(posedge SC_PointSCAN_CLOCK_50 or negedge SC_PointSCAN_RESET_InLow) begin
        if (!SC_PointSCAN_RESET_InLow) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            row_q    <= '1;
            col_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            row_q    <= row_d;
            col_q    <= col_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign SC_PointSCAN_row_OutBUS      = row_q;
    assign SC_PointSCAN_col_OutBUS      = col_q;
    assign SC_PointSCAN_rowindex_OutBUS = idx_q;
    assign SC_PointSCAN_frameDone_Out   = done_q;
    assign SC_PointSCAN_busy_Out        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_point_matrix_scanner.sv
`default_nettype none
// ============================================================================
// tb_sc_point_matrix_scanner : table vectors, corner sequences and randomized
// stimulus against a frame-position reference model.
// Revision: 1.0
// ============================================================================
module tb_sc_point_matrix_scanner;

    localparam int DW    = 8;
    localparam int ROWS  = 8;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
`ifdef POINTSCAN_GHOSTBLANK_EN
    localparam int BL = BLANK;
`else
    localparam int BL = 0;
`endif
    localparam int SEG  = DWELL + BL;
    localparam int FLEN = 1 + ROWS * DWELL + (ROWS - 1) * BL;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic [ROWS*DW-1:0]   rows;
    logic [ROWS-1:0]      row_o;
    logic [DW-1:0]        col_o;
    logic [2:0]           idx_o;
    logic                 done_o;
    logic                 busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    sc_point_matrix_scanner #(
        .DATAWIDTH    (DW),
        .ROWS         (ROWS),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .SC_PointSCAN_CLOCK_50        (clk),
        .SC_PointSCAN_RESET_InLow     (rst_n),
        .SC_PointSCAN_enable_In       (en),
        .SC_PointSCAN_rows_InBUS      (rows),
        .SC_PointSCAN_row_OutBUS      (row_o),
        .SC_PointSCAN_col_OutBUS      (col_o),
        .SC_PointSCAN_rowindex_OutBUS (idx_o),
        .SC_PointSCAN_frameDone_Out   (done_o),
        .SC_PointSCAN_busy_Out        (busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame (0 = LOAD cycle).
    bit         m_act  = 1'b0;
    int         m_pos  = 0;
    bit         m_done = 1'b0;
    logic [7:0] m_snap [ROWS];

    task automatic model_reset();
        m_act  = 1'b0;
        m_pos  = 0;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_act) begin
            if (en) begin
                m_act = 1'b1;
                m_pos = 0;
            end
        end else begin
            if (m_pos == 0) begin
                for (int r = 0; r < ROWS; r++) m_snap[r] = rows[r*DW +: DW];
            end
            m_pos++;
            if (m_pos == FLEN) begin
                m_done = 1'b1;
                m_pos  = 0;
                if (!en) m_act = 1'b0;
            end
        end
    endtask

    // Row currently lit per the model, or -1 when the matrix is dark.
    function automatic int model_lit_row();
        int q;
        if (!m_act || m_pos == 0) return -1;
        q = m_pos - 1;
        if ((q % SEG) < DWELL) return q / SEG;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic compare_model();
        logic [7:0] erow;
        logic [7:0] ecol;
        logic [7:0] one;
        int         lr;
        one  = 8'h01;
        lr   = model_lit_row();
        erow = 8'hFF;
        ecol = 8'h00;
        if (lr >= 0) begin
            erow = ~(one << lr);
            ecol = m_snap[lr];
        end
        check("model_outputs", {14'd0, row_o, col_o, done_o, busy_o},
                               {14'd0, erow, ecol, m_done, m_act});
        if (m_act && m_pos >= 1) check("model_rowindex", {29'd0, idx_o}, (m_pos - 1) / SEG);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    typedef struct {
        int         k;
        logic [7:0] row;
        logic [7:0] col;
        logic       done;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [7:0] one;
        int         seen_7f;
        int         budget;
        int         n_done;
        one = 8'h01;

`ifdef POINTSCAN_GHOSTBLANK_EN
        tbl[0] = '{1,  8'hFF, 8'h00, 1'b0};
        tbl[1] = '{2,  8'hFE, 8'h01, 1'b0};
        tbl[2] = '{5,  8'hFE, 8'h01, 1'b0};
        tbl[3] = '{6,  8'hFF, 8'h00, 1'b0};
        tbl[4] = '{8,  8'hFD, 8'h02, 1'b0};
        tbl[5] = '{14, 8'hFB, 8'h04, 1'b0};
        tbl[6] = '{47, 8'h7F, 8'h80, 1'b0};
        tbl[7] = '{48, 8'hFF, 8'h00, 1'b1};
`else
        tbl[0] = '{1,  8'hFF, 8'h00, 1'b0};
        tbl[1] = '{2,  8'hFE, 8'h01, 1'b0};
        tbl[2] = '{5,  8'hFE, 8'h01, 1'b0};
        tbl[3] = '{6,  8'hFD, 8'h02, 1'b0};
        tbl[4] = '{10, 8'hFB, 8'h04, 1'b0};
        tbl[5] = '{30, 8'h7F, 8'h80, 1'b0};
        tbl[6] = '{33, 8'h7F, 8'h80, 1'b0};
        tbl[7] = '{34, 8'hFF, 8'h00, 1'b1};
`endif

        // Reset with enable low, then idle for 20 clocks.
        rst_n = 1'b0;
        en    = 1'b0;
        rows  = '0;
        model_reset();
        repeat (3) step();
        check("reset_outputs", {14'd0, row_o, col_o, done_o, busy_o}, {14'd0, 8'hFF, 8'h00, 1'b0, 1'b0});
        check("reset_rowindex", {29'd0, idx_o}, 32'd0);
        rst_n = 1'b1;
        repeat (20) step();
        check("idle_after_20", {14'd0, row_o, col_o, done_o, busy_o}, {14'd0, 8'hFF, 8'h00, 1'b0, 1'b0});

        // Frame 1 with walking-one pattern, data changed to AA mid-frame.
        for (int r = 0; r < ROWS; r++) rows[r*DW +: DW] = one << r;
        en     = 1'b1;
        n_done = 0;
        for (int k = 1; k <= FLEN + 1; k++) begin
            step();
            if (done_o) n_done++;
            if (k == 3) rows = {ROWS{8'hAA}};
            for (int i = 0; i < 8; i++) begin
                if (tbl[i].k == k)
                    check($sformatf("table_k%0d", k), {23'd0, row_o, col_o, done_o},
                                                      {23'd0, tbl[i].row, tbl[i].col, tbl[i].done});
            end
        end
        check("frame1_done_count", n_done, 32'd1);

        // Frame 2 shows the data written during frame 1.
        step();
        check("frame2_row0", {16'd0, row_o, col_o}, {16'd0, 8'hFE, 8'hAA});
        repeat (SEG) step();
        check("frame2_row1", {16'd0, row_o, col_o}, {16'd0, 8'hFD, 8'hAA});

        // Drop enable while row 3 is lit; frame must complete, then idle.
        budget = 0;
        while (model_lit_row() != 3 && budget < 200) begin
            step();
            budget++;
        end
        check("reach_row3", {31'd0, (budget < 200)}, 32'd1);
        en      = 1'b0;
        seen_7f = 0;
        budget  = 0;
        while (!done_o && budget < 200) begin
            step();
            if (row_o == 8'h7F) seen_7f++;
            budget++;
        end
        check("disable_done_seen", {31'd0, done_o}, 32'd1);
        check("disable_row7_dwell", seen_7f, DWELL);
        check("disable_idle", {23'd0, row_o, col_o, busy_o}, {23'd0, 8'hFF, 8'h00, 1'b0});
        repeat (5) step();
        check("disable_stays_idle", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset while row 5 is lit.
        en     = 1'b1;
        budget = 0;
        while (model_lit_row() != 5 && budget < 200) begin
            step();
            budget++;
        end
        check("reach_row5", {31'd0, (budget < 200)}, 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_outputs", {14'd0, row_o, col_o, done_o, busy_o}, {14'd0, 8'hFF, 8'h00, 1'b0, 1'b0});
        check("async_reset_rowindex", {29'd0, idx_o}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("restart_load", {23'd0, row_o, col_o, busy_o}, {23'd0, 8'hFF, 8'h00, 1'b1});
        step();
        check("restart_row0", {16'd0, row_o, col_o}, {16'd0, 8'hFE, 8'hAA});

        // Randomized run against the model.
        for (int c = 0; c < 1500; c++) begin
            rows = {$urandom, $urandom};
            if ($urandom_range(0, 39) == 0) en = ~en;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
